// File: rtl/vga_pkg.sv
// Shared definitions for the VGA framebuffer arbiter: raster and
// framebuffer geometry, the 12-bit {R,G,B} pixel type and the
// arbiter state encoding.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int ADDR_W   = 15;

  typedef logic [11:0] rgb_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fb_addr_calc.sv
// Framebuffer linear address: addr_o = row_i * 160 + col_i.
// The row multiply is a constant one, done as (row<<7) + (row<<5).
//   col_i  : framebuffer column (0..159 when in range)
//   row_i  : framebuffer row (0..119 when in range)
//   addr_o : word address into the framebuffer RAM
module fb_addr_calc #(
  parameter int AW = 15
) (
  input  logic [7:0]    col_i,
  input  logic [6:0]    row_i,
  output logic [AW-1:0] addr_o
);

  logic [AW-1:0] row_w;

  assign row_w  = AW'(row_i);
  assign addr_o = (row_w << 7) + (row_w << 5) + AW'(col_i);

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter between VGA scan-out, a pixel writer
// and a hardware clear engine, plus the two-stage pixel output pipeline.
//   clk, rst                    : pixel clock, sync active-high reset
//   hcount/vcount/hsync_in/vsync_in : raster counter inputs
//   vblank_only                 : restrict writer grants to vertical blank
//   wr_req/wr_x/wr_y/wr_data    : writer request (held until wr_ack)
//   wr_ack/wr_drop              : request consumed / consumed but discarded
//   clr_req/clr_color/clr_busy  : clear start, fill colour, clear running
//   ram_addr/ram_we/ram_wdata/ram_rdata : single-port RAM (sync read)
//   red/green/blue/hsync/vsync  : registered VGA outputs, latency 2
module vga_fb_arbiter
  import vga_pkg::rgb_t;
  import vga_pkg::arb_state_e;
#(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int FB_W     = vga_pkg::FB_W,
  parameter int FB_H     = vga_pkg::FB_H,
  parameter int ADDR_W   = vga_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              vblank_only,
  input  logic              wr_req,
  input  logic [7:0]        wr_x,
  input  logic [6:0]        wr_y,
  input  logic [11:0]       wr_data,
  output logic              wr_ack,
  output logic              wr_drop,
  input  logic              clr_req,
  input  logic [11:0]       clr_color,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [11:0]       ram_wdata,
  input  logic [11:0]       ram_rdata,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              hsync,
  output logic              vsync
);

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_W * FB_H - 1);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  rgb_t              clr_color_q, clr_color_d;

  logic              active, disp_slot, wr_window, wr_oob;
  logic [ADDR_W-1:0] disp_addr, wr_addr;

  assign active    = (hcount < 10'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
  // Each framebuffer pixel spans 4 raster pixels; fetch once per group.
  assign disp_slot = active && (hcount[1:0] == 2'b00);
  assign wr_window = !vblank_only || (vcount >= 10'(V_ACTIVE));
  assign wr_oob    = (wr_x >= 8'(FB_W)) || (wr_y >= 7'(FB_H));
  assign clr_busy  = (state_q == vga_pkg::CLEAR);

  fb_addr_calc #(.AW(ADDR_W)) u_disp_addr (
    .col_i  (hcount[9:2]),
    .row_i  (vcount[8:2]),
    .addr_o (disp_addr)
  );

  fb_addr_calc #(.AW(ADDR_W)) u_wr_addr (
    .col_i  (wr_x),
    .row_i  (wr_y),
    .addr_o (wr_addr)
  );

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    clr_color_d = clr_color_q;
    wr_ack      = 1'b0;
    wr_drop     = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = disp_addr;
    ram_wdata   = wr_data;
    case (state_q)
      vga_pkg::IDLE: begin
        if (clr_req) begin
          // Clear entry takes precedence; the writer waits for the clear.
          state_d     = vga_pkg::CLEAR;
          clr_cnt_d   = '0;
          clr_color_d = clr_color;
        end else if (wr_req && wr_oob) begin
          // Out-of-range writes need no RAM slot, so retire them at once.
          wr_ack  = 1'b1;
          wr_drop = 1'b1;
        end else if (wr_req && !disp_slot && wr_window) begin
          wr_ack   = 1'b1;
          ram_we   = 1'b1;
          ram_addr = wr_addr;
        end
      end
      vga_pkg::CLEAR: begin
        if (!disp_slot) begin
          ram_we    = 1'b1;
          ram_addr  = clr_cnt_q;
          ram_wdata = clr_color_q;
          clr_cnt_d = clr_cnt_q + 1'b1;
          if (clr_cnt_q == CLR_LAST) state_d = vga_pkg::IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= vga_pkg::IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
    clr_color_q <= clr_color_d;
  end

  // ---- stage 1: raster position aligned with the RAM read ----
  logic [1:0] hph_p1_q;
  logic       act_p1_q, hs_p1_q, vs_p1_q;

  always_ff @(posedge clk) begin
    hph_p1_q <= hcount[1:0];
    if (rst) begin
      act_p1_q <= 1'b0;
      hs_p1_q  <= 1'b1;
      vs_p1_q  <= 1'b1;
    end else begin
      act_p1_q <= active;
      hs_p1_q  <= hsync_in;
      vs_p1_q  <= vsync_in;
    end
  end

  // ---- stage 2: colour select and output registers ----
  rgb_t pix_hold_q, pix_hold_d;
  rgb_t rgb_p2_q, rgb_p2_d;
  logic hs_p2_q, vs_p2_q;

  always_comb begin
    pix_hold_d = pix_hold_q;
    rgb_p2_d   = '0;
    if (act_p1_q && (hph_p1_q == 2'b00)) begin
      rgb_p2_d   = ram_rdata;
      pix_hold_d = ram_rdata;
    end else if (act_p1_q) begin
      rgb_p2_d = pix_hold_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_hold_q <= '0;
      rgb_p2_q   <= '0;
      hs_p2_q    <= 1'b1;
      vs_p2_q    <= 1'b1;
    end else begin
      pix_hold_q <= pix_hold_d;
      rgb_p2_q   <= rgb_p2_d;
      hs_p2_q    <= hs_p1_q;
      vs_p2_q    <= vs_p1_q;
    end
  end

  assign red   = rgb_p2_q[11:8];
  assign green = rgb_p2_q[7:4];
  assign blue  = rgb_p2_q[3:0];
  assign hsync = hs_p2_q;
  assign vsync = vs_p2_q;

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

- Shares one single-port 12-bit RGB framebuffer RAM (160x120, each pixel shown as a 4x4 block on the 640x480 raster) between display scan-out and a pixel writer.
- Also runs a hardware clear sequence over that RAM.
- Sits between the hcount/vcount/hsync/vsync counter and the VGA pins, in the 25 MHz domain.
- Scan-out always wins; writer and clear use every non-display cycle.

## Interface

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- FB_W, 160, framebuffer columns (H_ACTIVE>>2)
- FB_H, 120, framebuffer rows (V_ACTIVE>>2)
- ADDR_W, 15, RAM address width (covers FB_W*FB_H = 19200 words)

Ports:
- clk  in  1  25 MHz pixel clock
- rst  in  1  reset; synchronous, active-high
- hcount  in  10  horizontal position, 0..799
- vcount  in  10  vertical position, 0..524
- hsync_in, vsync_in  in  1  raw syncs from the counter, active-low
- vblank_only  in  1  1 = writer granted only while vcount >= V_ACTIVE
- wr_req  in  1  write request; wr_x/wr_y/wr_data held stable until wr_ack
- wr_x  in  8  framebuffer column
- wr_y  in  7  framebuffer row
- wr_data  in  12  {R,G,B} 4 bits each
- wr_ack  out  1  request consumed this cycle
- wr_drop  out  1  with wr_ack: coordinates out of range, nothing written
- clr_req  in  1  start clear (sampled when idle)
- clr_color  in  12  fill colour, latched at clear start
- clr_busy  out  1  clear in progress
- ram_addr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  12  RAM write data
- ram_rdata  in  12  RAM read data, valid one cycle after the address
- red, green, blue  out  4 each  registered pixel colour
- hsync, vsync  out  1  syncs delayed to match the pixel pipeline

## Operation

**Display slot (`disp_slot`)**
- Condition: hcount < H_ACTIVE, vcount < V_ACTIVE, hcount[1:0] == 0.
- Action: ram_addr = (vcount>>2)*FB_W + (hcount>>2), ram_we = 0.
- Multiply is by a constant, implemented as (v<<7)+(v<<5); result width ADDR_W.

**Free slot**
- Every cycle that is not a display slot.
- Owner is chosen by state, IDLE or CLEAR.

**IDLE**
- Writer is granted when all of: wr_req, free slot, and (!vblank_only or vcount >= V_ACTIVE).
- In-range request (wr_x < FB_W, wr_y < FB_H): wr_ack = 1, ram_we = 1, ram_addr = wr_y*FB_W + wr_x, ram_wdata = wr_data.
- Out-of-range request: wr_ack = 1 and wr_drop = 1 in the first cycle wr_req is seen, regardless of slot or mode; ram_we = 0.
- clr_req while IDLE: latch clr_color, clear clr_cnt, go to CLEAR. clr_busy is 1 from the next cycle.
- clr_req wins over a same-cycle wr_req: that cycle acts as CLEAR entry, no writer grant.

**CLEAR**
- Each free slot writes clr_color to clr_cnt, then clr_cnt++.
- vblank_only is ignored; wr_ack stays 0.
- After the write at clr_cnt == FB_W*FB_H-1: return to IDLE, clr_busy = 0 from the next cycle.
- clr_req while busy is ignored.

**Pixel pipeline**
- Stage 1 registers hcount, vcount, active flag and the syncs.
- Stage 2 computes the colour:
  - active and h_d1[1:0] == 0: RGB = ram_rdata, and pix_hold <= ram_rdata;
  - active otherwise: RGB = pix_hold;
  - inactive: RGB = 0.

**Reset**
- red, green, blue = 0; hsync = vsync = 1; wr_ack = wr_drop = 0; ram_we = 0; clr_busy = 0; state IDLE; pix_hold = 0.
- Reset in mid-clear aborts the clear; the RAM is left partially filled.

## Timing

- RGB/hsync/vsync at cycle t+2 correspond to hcount/vcount at cycle t: latency 2, syncs delayed identically.
- wr_ack is combinational and asserted in the same cycle the write commits at the clock edge; the writer may change request fields the next cycle.
- Free-mode worst-case grant wait in the active region is 1 cycle, because display takes 1 slot in 4.
- Full clear takes 19200 free slots: under 2 frames.
- ram_* outputs are combinational from hcount/vcount, state and writer inputs; the RAM read is synchronous.

## Structure

- Shared package vga_pkg holds:
  - H_ACTIVE, V_ACTIVE, FB_W, FB_H, ADDR_W;
  - the 12-bit rgb type;
  - the arbiter state enum {IDLE, CLEAR}.
- One sub-module, fb_addr_calc: (x, y) -> row*FB_W + col. Instantiated twice, once for display and once for writer.

## Test plan

- Display fetch: preload addr 0 = 0x906, addr 1 = 0x0F0; at v = 0, h = 0..7 -> RGB 0x906 on 4 cycles then 0x0F0 on 4 cycles, starting 2 cycles after h = 0. h >= 640 -> RGB 0.
- Writer contention: wr_req held at h = 3 (x=5, y=2, 0xABC) -> ack at h = 3, ram_addr 325, we = 1. Same request at h = 4 -> ack at h = 5, never at h = 4.
- vblank_only = 1, request at v = 100 -> no ack until v = 480, h = 0, then ack and write in that cycle.
- Out-of-range x = 160 -> wr_ack = wr_drop = 1 in the first request cycle, ram_we = 0.
- clr_req with color 0x00F, simultaneous wr_req -> clr_busy = 1 the next cycle, wr_ack stays 0 throughout. 19200 writes of 0x00F to addresses 0..19199, then clr_busy = 0 and the pending write is acked.
- rst at clr_cnt = 1000 -> next cycle clr_busy = 0, state IDLE, RGB = 0, hsync = vsync = 1.
